// File: rtl/memory_arbiter_pkg.sv
// Shared encodings, FSM states and owner tags for the unified-memory arbiter.
// The decoder uses the same memAccessControl encodings.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam int unsigned WAIT_CNT_W = $clog2(16);
  localparam int unsigned STARVE_W   = 3;
  localparam int unsigned STAT_W     = 16;
  localparam int unsigned EVT_W      = 8;

  // A data request only counts when it carries an operation.
  function automatic logic data_req_valid(input logic req, input logic [1:0] op);
    return req && (op != MEM_NONE);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter that paces memory wait states; o_zero marks the
// last access cycle.
module arb_wait_counter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned W = WAIT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and data access.
// Optional grant statistics are enabled with the ARB_STATS_EN macro.
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetchReq,
  input  logic [ADDR_WIDTH-1:0] fetchAddr,
  output logic                  fetchAck,
  output logic [DATA_WIDTH-1:0] fetchData,
  input  logic                  dataReq,
  input  logic [1:0]            memAccessControl,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [DATA_WIDTH-1:0] dataWriteData,
  output logic                  dataAck,
  output logic [DATA_WIDTH-1:0] dataReadData,
  output logic                  accessError,
  output logic                  memEnable,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memReadData,
`ifdef ARB_STATS_EN
  output logic [STAT_W-1:0]     fetchGrantCount,
  output logic [STAT_W-1:0]     dataGrantCount,
  output logic [EVT_W-1:0]      starveEvents,
`endif
  output logic                  busy
);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  owner_t                r_owner;
  mem_op_t               r_op;
  mem_op_t               w_grant_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_fetch_data;
  logic [DATA_WIDTH-1:0] r_data_rdata;
  logic [STARVE_W-1:0]   r_starve_cnt;
  logic                  w_data_valid;
  logic                  w_starved;
  logic                  w_grant_fetch;
  logic                  w_grant_data;
  logic                  w_wait_zero;
  logic                  w_capture;

  assign w_data_valid = data_req_valid(dataReq, memAccessControl);
  assign w_starved    = (r_starve_cnt == STARVE_W'(STARVE_LIMIT));

  arb_wait_counter #(
    .W(WAIT_CNT_W)
  ) u_wait_counter (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_grant_fetch | w_grant_data),
    .i_load_val(WAIT_CNT_W'(WAIT_STATES)),
    .i_dec     (r_state == ACCESS),
    .o_zero    (w_wait_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration happens only in IDLE; reserved ops bypass the memory.
  always_comb begin
    w_next_state  = r_state;
    w_grant_fetch = 1'b0;
    w_grant_data  = 1'b0;
    w_grant_op    = MEM_READ;
    case (r_state)
      IDLE: begin
        if (fetchReq && (!w_data_valid || w_starved)) begin
          w_grant_fetch = 1'b1;
        end else if (w_data_valid) begin
          w_grant_data = 1'b1;
          w_grant_op   = mem_op_t'(memAccessControl);
        end
        if (w_grant_data && (w_grant_op == MEM_RSVD)) begin
          w_next_state = DONE;
        end else if (w_grant_fetch || w_grant_data) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (w_wait_zero) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_capture = (r_state == ACCESS) && w_wait_zero && (r_op == MEM_READ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OWN_FETCH;
      r_op         <= MEM_NONE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_fetch_data <= '0;
      r_data_rdata <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_grant_fetch) begin
        r_owner      <= OWN_FETCH;
        r_op         <= MEM_READ;
        r_addr       <= fetchAddr;
        r_starve_cnt <= '0;
      end else if (w_grant_data) begin
        r_owner <= OWN_DATA;
        r_op    <= w_grant_op;
        r_addr  <= dataAddr;
        r_wdata <= dataWriteData;
        // Fetch lost a contended arbitration.
        if (fetchReq && !w_starved) begin
          r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
      end
      if (w_capture) begin
        if (r_owner == OWN_FETCH) begin
          r_fetch_data <= memReadData;
        end else begin
          r_data_rdata <= memReadData;
        end
      end
    end
  end

  assign memEnable    = (r_state == ACCESS);
  assign memWrite     = memEnable && (r_op == MEM_WRITE);
  assign memAddr      = r_addr;
  assign memWriteData = r_wdata;
  assign fetchAck     = (r_state == DONE) && (r_owner == OWN_FETCH);
  assign dataAck      = (r_state == DONE) && (r_owner == OWN_DATA);
  assign accessError  = dataAck && (r_op == MEM_RSVD);
  assign fetchData    = r_fetch_data;
  assign dataReadData = r_data_rdata;
  assign busy         = (r_state != IDLE);

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] r_fetch_grants;
  logic [STAT_W-1:0] r_data_grants;
  logic [EVT_W-1:0]  r_starve_events;
  logic              w_forced;

  assign w_forced = w_grant_fetch && w_data_valid && w_starved;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_grants  <= '0;
      r_data_grants   <= '0;
      r_starve_events <= '0;
    end else begin
      if (w_grant_fetch && (r_fetch_grants != '1)) begin
        r_fetch_grants <= r_fetch_grants + STAT_W'(1);
      end
      if (w_grant_data && (r_data_grants != '1)) begin
        r_data_grants <= r_data_grants + STAT_W'(1);
      end
      if (w_forced && (r_starve_events != '1)) begin
        r_starve_events <= r_starve_events + EVT_W'(1);
      end
    end
  end

  assign fetchGrantCount = r_fetch_grants;
  assign dataGrantCount  = r_data_grants;
  assign starveEvents    = r_starve_events;
`endif

endmodule
